idma_cmd_arbiter: RTL and testbench

Shares the single iDMA command/response port between `NUM_REQ` requesters, e.g. the TX descriptor fetcher, the TX data fetcher and the RX buffer writer. Requests are granted round-robin and issued to iDMA one at a time. The requester index of every issued command is recorded in an in-order tag FIFO so that each iDMA completion returns to the requester that issued it. The block sits between the e1000 engines and the iDMA.

---
 rtl/e1000_pkg.sv | 27 ++
 rtl/idma_tag_fifo.sv | 69 ++++++
 rtl/idma_cmd_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_idma_cmd_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e1000_pkg.sv
// Shared definitions for the e1000 engines and their iDMA front end.
//   clogb2      : ceil(log2(value)), never less than 1, for sizing index and count fields.
//   IDMA_*_W    : widths of the iDMA command / completion fields.
//   arb_state_e : issue FSM states of idma_cmd_arbiter.
package e1000_pkg;

  localparam int unsigned IDMA_SRC_W = 64;
  localparam int unsigned IDMA_DST_W = 16;
  localparam int unsigned IDMA_LEN_W = 16;

  typedef enum logic {
    StIdle,
    StIssue
  } arb_state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/idma_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding iDMA command.
// Ports:
//   aclk, areset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write din at the tail (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   head          : entry at the head of the FIFO
//   cnt           : occupancy, 0..DEPTH
//   full, empty   : occupancy flags
// DEPTH must be a power of two (at least 2) so the pointers wrap by plain overflow.
module idma_tag_fifo
  import e1000_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned AW   = clogb2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/idma_cmd_arbiter.sv
// Shares one iDMA command/response port between NUM_REQ requesters. Commands are granted
// (round-robin by default) and issued one at a time; the requester index of every issued
// command goes into an in-order tag FIFO so each completion is routed back to its issuer.
// Ports (requester k occupies slice k of every packed per-requester vector):
//   aclk, areset        : clock, synchronous active-high reset
//   req_*, req_valid    : per-requester command payload and valid
//   req_ready           : grant, one-hot or zero, combinational in the grant cycle
//   idma_*, idma_valid  : registered command towards iDMA, held until idma_ready
//   irpt_*, irpt_valid  : completion from iDMA; irpt_ready accepts it
//   rsp_*               : completion fields broadcast to all requesters
//   rsp_valid           : completion valid, routed to the head-of-FIFO requester
//   rsp_ready           : per-requester completion ready
//   busy                : a command is being issued or any command is outstanding
//   err_orphan          : sticky, a completion arrived with nothing outstanding
// Build option: define IDMA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module idma_cmd_arbiter
  import e1000_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [IDMA_SRC_W*NUM_REQ-1:0] req_src_addr,
  input  logic [IDMA_DST_W*NUM_REQ-1:0] req_dst_addr,
  input  logic [IDMA_LEN_W*NUM_REQ-1:0] req_bytes,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [IDMA_SRC_W-1:0]         idma_src_addr,
  output logic [IDMA_DST_W-1:0]         idma_dst_addr,
  output logic [IDMA_LEN_W-1:0]         idma_bytes,
  output logic                          idma_valid,
  input  logic                          idma_ready,
  input  logic [IDMA_SRC_W-1:0]         irpt_src_addr,
  input  logic [IDMA_DST_W-1:0]         irpt_dst_addr,
  input  logic [IDMA_LEN_W-1:0]         irpt_bytes,
  input  logic                          irpt_valid,
  output logic                          irpt_ready,
  output logic [IDMA_SRC_W-1:0]         rsp_src_addr,
  output logic [IDMA_DST_W-1:0]         rsp_dst_addr,
  output logic [IDMA_LEN_W-1:0]         rsp_bytes,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          busy,
  output logic                          err_orphan
);

  localparam int unsigned IdxW = clogb2(NUM_REQ);
  localparam int unsigned CntW = clogb2(OUTSTANDING) + 1;

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       gnt_idx_q;
  logic [IdxW-1:0]       winner, cand;
  logic                  found, grant, push, pop;
  logic [IDMA_SRC_W-1:0] src_q, sel_src;
  logic [IDMA_DST_W-1:0] dst_q, sel_dst;
  logic [IDMA_LEN_W-1:0] len_q, sel_len;
  logic                  err_orphan_q;
  logic [IdxW-1:0]       tag_head;
  logic [CntW-1:0]       tag_cnt;
  logic                  tag_full, tag_empty;

`ifndef IDMA_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0]       last_q;
`endif

  // Winner selection among the currently valid requesters.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
`ifdef IDMA_ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`else
    // Search starts just after the last winner and wraps, so the last winner is tried last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  // Payload of the winning requester.
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == IdxW'(k)) begin
        sel_src = req_src_addr[k*IDMA_SRC_W +: IDMA_SRC_W];
        sel_dst = req_dst_addr[k*IDMA_DST_W +: IDMA_DST_W];
        sel_len = req_bytes[k*IDMA_LEN_W +: IDMA_LEN_W];
      end
    end
  end

  // Issue FSM: next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    idma_valid = 1'b0;
    grant      = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Full FIFO means OUTSTANDING commands are in flight; hold off new grants.
        if (found && !tag_full) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_d           = StIssue;
        end
      end
      StIssue: begin
        idma_valid = 1'b1;
        if (idma_ready) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      gnt_idx_q <= '0;
`ifndef IDMA_ARB_FIXED_PRIO_EN
      last_q    <= IdxW'(NUM_REQ - 1);
`endif
    end else if (grant) begin
      src_q     <= sel_src;
      dst_q     <= sel_dst;
      len_q     <= sel_len;
      gnt_idx_q <= winner;
`ifndef IDMA_ARB_FIXED_PRIO_EN
      last_q    <= winner;
`endif
    end
  end

  assign idma_src_addr = src_q;
  assign idma_dst_addr = dst_q;
  assign idma_bytes    = len_q;

  idma_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (IdxW)
  ) u_tag_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    (gnt_idx_q),
    .head   (tag_head),
    .cnt    (tag_cnt),
    .full   (tag_full),
    .empty  (tag_empty)
  );

  // Completion routing is purely combinational: the head tag picks the destination.
  always_comb begin
    rsp_valid  = '0;
    irpt_ready = 1'b0;
    if (!tag_empty) begin
      rsp_valid[tag_head] = irpt_valid;
      irpt_ready          = rsp_ready[tag_head];
    end
  end

  assign pop          = irpt_valid && irpt_ready;
  assign rsp_src_addr = irpt_src_addr;
  assign rsp_dst_addr = irpt_dst_addr;
  assign rsp_bytes    = irpt_bytes;

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_orphan_q <= 1'b0;
    end else if (irpt_valid && tag_empty) begin
      err_orphan_q <= 1'b1;
    end
  end

  assign err_orphan = err_orphan_q;
  assign busy       = (state_q == StIssue) || (tag_cnt != '0);

endmodule

// File: tb/tb_idma_cmd_arbiter.sv
// Bench for idma_cmd_arbiter (NUM_REQ=2, OUTSTANDING=4): reset values, a directed vector
// table, a hand-written reset-during-issue sequence, and a randomized run against a
// queue-based reference model.
module tb_idma_cmd_arbiter;

  localparam int NR  = 2;
  localparam int OUT = 4;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [64*NR-1:0] req_src_addr = '0;
  logic [16*NR-1:0] req_dst_addr = '0;
  logic [16*NR-1:0] req_bytes = '0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [63:0]     idma_src_addr;
  logic [15:0]     idma_dst_addr;
  logic [15:0]     idma_bytes;
  logic            idma_valid;
  logic            idma_ready = 1'b0;
  logic [63:0]     irpt_src_addr = '0;
  logic [15:0]     irpt_dst_addr = '0;
  logic [15:0]     irpt_bytes = '0;
  logic            irpt_valid = 1'b0;
  logic            irpt_ready;
  logic [63:0]     rsp_src_addr;
  logic [15:0]     rsp_dst_addr;
  logic [15:0]     rsp_bytes;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready = '0;
  logic            busy;
  logic            err_orphan;

  always #5 aclk = ~aclk;

  idma_cmd_arbiter #(
    .NUM_REQ     (NR),
    .OUTSTANDING (OUT)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_src_addr  (req_src_addr),
    .req_dst_addr  (req_dst_addr),
    .req_bytes     (req_bytes),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .idma_src_addr (idma_src_addr),
    .idma_dst_addr (idma_dst_addr),
    .idma_bytes    (idma_bytes),
    .idma_valid    (idma_valid),
    .idma_ready    (idma_ready),
    .irpt_src_addr (irpt_src_addr),
    .irpt_dst_addr (irpt_dst_addr),
    .irpt_bytes    (irpt_bytes),
    .irpt_valid    (irpt_valid),
    .irpt_ready    (irpt_ready),
    .rsp_src_addr  (rsp_src_addr),
    .rsp_dst_addr  (rsp_dst_addr),
    .rsp_bytes     (rsp_bytes),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .err_orphan    (err_orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fixed payloads for the directed parts.
  logic [63:0] p_src [NR];
  logic [15:0] p_dst [NR];
  logic [15:0] p_len [NR];

  task automatic load_fixed_payload();
    p_src[0] = 64'h1111_0000_0000_0a00;
    p_src[1] = 64'h2222_0000_0000_0b00;
    p_dst[0] = 16'h0a10;
    p_dst[1] = 16'h0b10;
    p_len[0] = 16'h0040;
    p_len[1] = 16'h0080;
    for (int k = 0; k < NR; k++) begin
      req_src_addr[k*64 +: 64] = p_src[k];
      req_dst_addr[k*16 +: 16] = p_dst[k];
      req_bytes[k*16 +: 16]    = p_len[k];
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req_valid = '0;
    idma_ready = 1'b0;
    irpt_valid = 1'b0;
    rsp_ready = '0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic drive(input logic [1:0] rv, input logic ir, input logic iv,
                       input logic [1:0] rr);
    req_valid = rv;
    idma_ready = ir;
    irpt_valid = iv;
    rsp_ready = rr;
    #4;
  endtask

  // ---------------------------------------------------------------- directed vector table
  typedef struct {
    logic [1:0] rv;
    logic       ir;
    logic       iv;
    logic [1:0] rr;
    logic [1:0] e_rdy;
    logic       e_val;
    int         e_src;   // requester whose payload idma_* must carry, -1 = not checked
    logic [1:0] e_rsp;
    logic       e_irdy;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rv, input logic ir, input logic iv,
                              input logic [1:0] rr, input logic [1:0] e_rdy,
                              input logic e_val, input int e_src, input logic [1:0] e_rsp,
                              input logic e_irdy, input logic e_busy, input logic e_err);
    vec_t v;
    v.rv = rv; v.ir = ir; v.iv = iv; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_src = e_src; v.e_rsp = e_rsp;
    v.e_irdy = e_irdy; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int n);
    irpt_src_addr = 64'hc0de_0000_0000_0000 | 64'(n);
    irpt_dst_addr = 16'h5500 | 16'(n);
    irpt_bytes    = 16'h0100 + 16'(n);
    drive(v.rv, v.ir, v.iv, v.rr);
    check($sformatf("v%0d req_ready", n), req_ready, v.e_rdy);
    check($sformatf("v%0d idma_valid", n), idma_valid, v.e_val);
    check($sformatf("v%0d rsp_valid", n), rsp_valid, v.e_rsp);
    check($sformatf("v%0d irpt_ready", n), irpt_ready, v.e_irdy);
    check($sformatf("v%0d busy", n), busy, v.e_busy);
    check($sformatf("v%0d err_orphan", n), err_orphan, v.e_err);
    check($sformatf("v%0d rsp_src", n), rsp_src_addr, 64'hc0de_0000_0000_0000 | 64'(n));
    if (v.e_src >= 0) begin
      check($sformatf("v%0d idma_src", n), idma_src_addr, p_src[v.e_src]);
      check($sformatf("v%0d idma_dst", n), idma_dst_addr, p_dst[v.e_src]);
      check($sformatf("v%0d idma_bytes", n), idma_bytes, p_len[v.e_src]);
    end
    tick();
  endtask

  // ---------------------------------------------------------------- reference model
  int          tagq[$];
  bit          m_issue;
  int          m_gnt;
  int          m_last;
  bit          m_err;
  logic [63:0] m_src;
  logic [15:0] m_dst, m_len;

  task automatic model_reset();
    tagq.delete();
    m_issue = 1'b0;
    m_gnt = 0;
    m_last = NR - 1;
    m_err = 1'b0;
    m_src = '0;
    m_dst = '0;
    m_len = '0;
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    int idx;
`ifdef IDMA_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) begin
      if (((v >> i) & 1'b1) != 0) return i;
    end
    idx = last;
`else
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (((v >> idx) & 1'b1) != 0) return idx;
    end
`endif
    return -1;
  endfunction

  initial begin
    load_fixed_payload();
    do_reset();

    // Reset values.
    drive(2'b00, 1'b0, 1'b0, 2'b00);
    check("rst req_ready", req_ready, 2'b00);
    check("rst idma_valid", idma_valid, 1'b0);
    check("rst idma_src", idma_src_addr, 64'h0);
    check("rst idma_dst", idma_dst_addr, 16'h0);
    check("rst idma_bytes", idma_bytes, 16'h0);
    check("rst rsp_valid", rsp_valid, 2'b00);
    check("rst irpt_ready", irpt_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst err_orphan", err_orphan, 1'b0);
    tick();

`ifdef IDMA_ARB_FIXED_PRIO_EN
    // Both requesters always valid, completions drained continuously: requester 0 wins each time.
    for (int c = 0; c < 12; c++) begin
      drive(2'b11, 1'b1, 1'b1, 2'b11);
      if (c % 2 == 0) begin
        check($sformatf("fp%0d req_ready", c), req_ready, 2'b01);
      end else begin
        check($sformatf("fp%0d idma_valid", c), idma_valid, 1'b1);
        check($sformatf("fp%0d idma_src", c), idma_src_addr, p_src[0]);
      end
      tick();
    end
`else
    begin
      vec_t vecs[$];
      // Round-robin, back-to-back grants, fill to OUTSTANDING.
      for (int i = 0; i < 4; i++) begin
        vecs.push_back(mk(2'b11, 1'b1, 1'b0, 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, -1,
                          2'b00, (i == 0) ? 1'b0 : 1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0));
        vecs.push_back(mk(2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, i % 2, 2'b00,
                          (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0));
      end
      // Full: no grant until a completion frees a slot.
      vecs.push_back(mk(2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, -1, 2'b00, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, -1, 2'b00, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b01, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b11, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0, -1, 2'b00, 1'b1, 1'b1, 1'b0));
      // Simultaneous push and pop, then drain; head must be 0,1,0 in that order.
      vecs.push_back(mk(2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 0, 2'b10, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, -1, 2'b01, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b01, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b10, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b01, 1'b1, 1'b1, 1'b0));
      // Orphan completion.
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, -1, 2'b00, 1'b0, 1'b0, 1'b1));
      // Issue req1 then req0; completions route 2'b10 then 2'b01, first one stalled.
      vecs.push_back(mk(2'b10, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0, -1, 2'b00, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(2'b01, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1, 2'b00, 1'b0, 1'b1, 1'b1));
      vecs.push_back(mk(2'b01, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0, -1, 2'b00, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 0, 2'b00, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, -1, 2'b10, 1'b0, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, -1, 2'b10, 1'b0, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b10, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, -1, 2'b01, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, -1, 2'b00, 1'b0, 1'b0, 1'b1));
      for (int n = 0; n < vecs.size(); n++) begin
        apply_vec(vecs[n], n);
      end
    end
`endif

    // Orphan, then reset asserted while a command is held in the issue state.
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    check("orph irpt_ready", irpt_ready, 1'b0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    check("orph err_orphan", err_orphan, 1'b1);
    tick();
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    check("mid req_ready a", req_ready, 2'b01);
    tick();
    drive(2'b00, 1'b1, 1'b0, 2'b11);
    check("mid idma_valid a", idma_valid, 1'b1);
    tick();
    drive(2'b01, 1'b0, 1'b0, 2'b11);
    check("mid req_ready b", req_ready, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    check("mid idma_valid b", idma_valid, 1'b1);
    check("mid busy", busy, 1'b1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    check("post idma_valid", idma_valid, 1'b0);
    check("post err_orphan", err_orphan, 1'b0);
    check("post busy", busy, 1'b0);
    check("post irpt_ready", irpt_ready, 1'b0);
    check("post rsp_valid", rsp_valid, 2'b00);
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    check("post err_orphan set", err_orphan, 1'b1);
    tick();

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int          w;
      logic [NR-1:0] e_rdy, e_rsp;
      logic        e_irdy;
      req_valid     = NR'($urandom);
      idma_ready    = ($urandom_range(0, 3) != 0);
      irpt_valid    = ($urandom_range(0, 2) == 0);
      rsp_ready     = NR'($urandom) | NR'($urandom);
      areset        = ($urandom_range(0, 299) == 0);
      req_src_addr  = {$urandom, $urandom, $urandom, $urandom};
      req_dst_addr  = 32'($urandom);
      req_bytes     = 32'($urandom);
      irpt_src_addr = {$urandom, $urandom};
      irpt_dst_addr = 16'($urandom);
      irpt_bytes    = 16'($urandom);
      #4;
      if (areset) begin
        model_reset();
      end else begin
        w = (!m_issue && tagq.size() < OUT) ? pick(req_valid, m_last) : -1;
        e_rdy = (w >= 0) ? (NR'(1) << w) : '0;
        e_irdy = (tagq.size() > 0) && (((rsp_ready >> tagq[0]) & 1'b1) != 0);
        e_rsp = (irpt_valid && tagq.size() > 0) ? (NR'(1) << tagq[0]) : '0;
        check("rnd req_ready", req_ready, e_rdy);
        check("rnd idma_valid", idma_valid, m_issue);
        check("rnd rsp_valid", rsp_valid, e_rsp);
        check("rnd irpt_ready", irpt_ready, e_irdy);
        check("rnd busy", busy, m_issue || tagq.size() > 0);
        check("rnd err_orphan", err_orphan, m_err);
        check("rnd rsp_fields", {rsp_src_addr, rsp_dst_addr, rsp_bytes} == {irpt_src_addr,
              irpt_dst_addr, irpt_bytes}, 1'b1);
        if (m_issue) begin
          check("rnd idma_cmd", {idma_src_addr, idma_dst_addr, idma_bytes} ==
                {m_src, m_dst, m_len}, 1'b1);
        end
        if (irpt_valid && tagq.size() == 0) m_err = 1'b1;
        if (irpt_valid && e_irdy) void'(tagq.pop_front());
        if (m_issue && idma_ready) begin
          tagq.push_back(m_gnt);
          m_issue = 1'b0;
        end
        if (w >= 0) begin
          m_issue = 1'b1;
          m_gnt   = w;
          m_last  = w;
          m_src   = req_src_addr[w*64 +: 64];
          m_dst   = req_dst_addr[w*16 +: 16];
          m_len   = req_bytes[w*16 +: 16];
        end
      end
      tick();
    end
    areset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
